// File: rtl/word_tx_pkg.sv
// Shared byte-stream definitions used by the word serializer and its
// receive-side counterpart.
package word_tx_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } io_state_t;

endpackage

// File: rtl/word_tx.sv
// Word serializer: sends one WORD_BYTES-wide word to a byte transmitter,
// least-significant byte first, with an optional idle gap between bytes.
// All state updates on the falling edge of clk; rst is synchronous.
module word_tx
   import word_tx_pkg::*;
#(
   parameter int WORD_BYTES = 4,
   parameter int GAP_CYCLES = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [BYTE_W*WORD_BYTES-1:0] in,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic [BYTE_W-1:0]            byte_out,
   output logic                         byte_start,
   input  logic                         byte_done
);

   localparam int WORD_W = BYTE_W * WORD_BYTES;
   localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   io_state_t          state_reg, state_next;
   logic [WORD_W-1:0]  shreg_reg, shreg_next;
   logic [IDX_W-1:0]   index_reg, index_next;
   logic [GAP_W-1:0]   gap_reg, gap_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;
   logic               byte_start_reg, byte_start_next;
   logic [BYTE_W-1:0]  byte_out_reg, byte_out_next;

   // Next-state and registered-output computation; pulses default low.
   always_comb begin
      state_next      = state_reg;
      shreg_next      = shreg_reg;
      index_next      = index_reg;
      gap_next        = gap_reg;
      busy_next       = busy_reg;
      done_next       = 1'b0;
      byte_start_next = 1'b0;
      byte_out_next   = byte_out_reg;
      case (state_reg)
         IDLE: begin
            // done may be high here; a start in the same cycle is still taken
            if (start) begin
               shreg_next = in;
               index_next = '0;
               busy_next  = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            byte_out_next   = shreg_reg[BYTE_W-1:0];
            byte_start_next = 1'b1;
            state_next      = WAIT;
         end
         WAIT: begin
            if (byte_done) begin
               if (index_reg == LAST_IDX) begin
                  done_next  = 1'b1;
                  busy_next  = 1'b0;
                  state_next = IDLE;
               end else begin
                  shreg_next = shreg_reg >> BYTE_W;
                  index_next = index_reg + 1'b1;
                  gap_next   = '0;
                  if (GAP_CYCLES > 0) state_next = GAP;
                  else                state_next = ISSUE;
               end
            end
         end
         GAP: begin
            if (gap_reg == LAST_GAP) begin
               gap_next   = '0;
               state_next = ISSUE;
            end else begin
               gap_next = gap_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and output registers, falling-edge clocked with synchronous reset.
   always_ff @(negedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         shreg_reg      <= '0;
         index_reg      <= '0;
         gap_reg        <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         byte_start_reg <= 1'b0;
         byte_out_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         shreg_reg      <= shreg_next;
         index_reg      <= index_next;
         gap_reg        <= gap_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
         byte_start_reg <= byte_start_next;
         byte_out_reg   <= byte_out_next;
      end
   end

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign byte_start = byte_start_reg;
   assign byte_out   = byte_out_reg;

endmodule

// File: tb/tb_word_tx.sv
// Directed bench for word_tx: a no-gap instance and a GAP_CYCLES=3 instance,
// each driven by a byte-transmitter model that logs bytes and answers
// byte_start with byte_done after a programmable latency.
module tb_word_tx;

   logic clk = 1'b1;
   logic rst;

   logic        start_a, busy_a, done_a, byte_start_a, byte_done_a;
   logic [31:0] in_a;
   logic [7:0]  byte_out_a;
   logic        resp_done_a = 1'b0;
   logic        man_done_a;

   logic        start_b, busy_b, done_b, byte_start_b, byte_done_b;
   logic [31:0] in_b;
   logic [7:0]  byte_out_b;
   logic        resp_done_b = 1'b0;

   assign byte_done_a = resp_done_a | man_done_a;
   assign byte_done_b = resp_done_b;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] bytes_a[$];
   logic [7:0] bytes_b[$];
   int         gaps_a[$];
   int         gaps_b[$];
   int         done_pulses_a = 0;

   int  cnt_a = 0, cnt_b = 0;
   bit  pend_a = 0, pend_b = 0;
   bit  have_a = 0, have_b = 0;
   time t_done_a = 0, t_done_b = 0;
   bit  rand_lat = 0;
   int  lat_a = 10;

   always #5 clk = ~clk;

   word_tx #(.WORD_BYTES(4), .GAP_CYCLES(0)) dut_a (
      .clk(clk), .rst(rst), .in(in_a), .start(start_a), .busy(busy_a),
      .done(done_a), .byte_out(byte_out_a), .byte_start(byte_start_a),
      .byte_done(byte_done_a)
   );

   word_tx #(.WORD_BYTES(4), .GAP_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst), .in(in_b), .start(start_b), .busy(busy_b),
      .done(done_b), .byte_out(byte_out_b), .byte_start(byte_start_b),
      .byte_done(byte_done_b)
   );

   // Byte transmitter model for the no-gap instance.
   always @(posedge clk) begin
      resp_done_a = 1'b0;
      if (rst) begin
         pend_a = 0;
         have_a = 0;
      end else begin
         if (done_a) begin
            have_a = 0;
            done_pulses_a++;
         end
         if (pend_a) begin
            if (cnt_a == 0) begin
               resp_done_a = 1'b1;
               pend_a      = 0;
               t_done_a    = $time;
               have_a      = 1;
            end else begin
               cnt_a--;
            end
         end
         if (byte_start_a) begin
            bytes_a.push_back(byte_out_a);
            if (have_a) begin
               gaps_a.push_back(int'(($time - t_done_a) / 10));
               have_a = 0;
            end
            pend_a = 1;
            cnt_a  = (rand_lat ? int'($urandom_range(20, 1)) : lat_a) - 1;
         end
      end
   end

   // Byte transmitter model for the gapped instance, fixed latency of 4.
   always @(posedge clk) begin
      resp_done_b = 1'b0;
      if (rst) begin
         pend_b = 0;
         have_b = 0;
      end else begin
         if (done_b) have_b = 0;
         if (pend_b) begin
            if (cnt_b == 0) begin
               resp_done_b = 1'b1;
               pend_b      = 0;
               t_done_b    = $time;
               have_b      = 1;
            end else begin
               cnt_b--;
            end
         end
         if (byte_start_b) begin
            bytes_b.push_back(byte_out_b);
            if (have_b) begin
               gaps_b.push_back(int'(($time - t_done_b) / 10));
               have_b = 0;
            end
            pend_b = 1;
            cnt_b  = 3;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done_a(input string tag, input int budget);
      int k = 0;
      while (done_a !== 1'b1 && k < budget) begin
         cyc();
         k++;
      end
      chk(tag, {31'd0, done_a}, 32'd1);
   endtask

   task automatic wait_done_b(input string tag, input int budget);
      int k = 0;
      while (done_b !== 1'b1 && k < budget) begin
         cyc();
         k++;
      end
      chk(tag, {31'd0, done_b}, 32'd1);
   endtask

   // Reassemble the oldest four logged bytes, first byte into bits [7:0].
   function automatic logic [31:0] pop_a();
      logic [31:0] w = 'x;
      if (bytes_a.size() >= 4)
         for (int i = 0; i < 4; i++) w[8*i +: 8] = bytes_a.pop_front();
      return w;
   endfunction

   function automatic logic [31:0] pop_b();
      logic [31:0] w = 'x;
      if (bytes_b.size() >= 4)
         for (int i = 0; i < 4; i++) w[8*i +: 8] = bytes_b.pop_front();
      return w;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          dp;
      int          nbd;
      int          k;
      logic [31:0] w;

      rst = 1'b1;
      start_a = 1'b0; in_a = '0; man_done_a = 1'b0;
      start_b = 1'b0; in_b = '0;
      repeat (3) cyc();

      // Reset state
      chk("rst busy_a", {31'd0, busy_a}, 32'd0);
      chk("rst done_a", {31'd0, done_a}, 32'd0);
      chk("rst byte_start_a", {31'd0, byte_start_a}, 32'd0);
      chk("rst byte_out_a", {24'd0, byte_out_a}, 32'd0);
      chk("rst busy_b", {31'd0, busy_b}, 32'd0);
      chk("rst byte_out_b", {24'd0, byte_out_b}, 32'd0);
      rst = 1'b0;
      cyc();

      // Single word with latency check and a start pulsed while busy
      bytes_a.delete(); gaps_a.delete();
      start_a = 1'b1; in_a = 32'hDEADBEEF;
      cyc();
      start_a = 1'b0; in_a = '0;
      chk("accept busy", {31'd0, busy_a}, 32'd1);
      chk("accept no byte_start", {31'd0, byte_start_a}, 32'd0);
      cyc();
      chk("first byte_start", {31'd0, byte_start_a}, 32'd1);
      chk("first byte_out", {24'd0, byte_out_a}, 32'h000000EF);
      cyc();
      chk("byte_start one cycle", {31'd0, byte_start_a}, 32'd0);
      start_a = 1'b1; in_a = 32'h12345678;
      cyc();
      start_a = 1'b0; in_a = '0;
      wait_done_a("w1 done", 400);
      chk("w1 byte count", bytes_a.size(), 32'd4);
      chk("w1 word", pop_a(), 32'hDEADBEEF);
      chk("w1 gap count", gaps_a.size(), 32'd3);
      for (int i = 0; i < 3; i++) chk("w1 done-to-start edges", gaps_a[i], 32'd2);
      cyc();
      chk("w1 done pulse width", {31'd0, done_a}, 32'd0);
      chk("w1 busy after", {31'd0, busy_a}, 32'd0);
      repeat (30) cyc();
      chk("start while busy not queued", bytes_a.size(), 32'd0);

      // byte_done in IDLE is ignored
      dp = done_pulses_a;
      man_done_a = 1'b1;
      cyc();
      man_done_a = 1'b0;
      repeat (5) cyc();
      chk("idle byte_done no bytes", bytes_a.size(), 32'd0);
      chk("idle byte_done busy", {31'd0, busy_a}, 32'd0);
      chk("idle byte_done no done", done_pulses_a, dp);

      // Back-to-back words
      start_a = 1'b1; in_a = 32'hCAFEF00D;
      cyc();
      start_a = 1'b0; in_a = '0;
      wait_done_a("b2b first done", 400);
      start_a = 1'b1; in_a = 32'h01234567;
      cyc();
      start_a = 1'b0; in_a = '0;
      chk("b2b accept busy", {31'd0, busy_a}, 32'd1);
      cyc();
      chk("b2b no idle cycle", {31'd0, byte_start_a}, 32'd1);
      wait_done_a("b2b second done", 400);
      chk("b2b byte count", bytes_a.size(), 32'd8);
      chk("b2b word 1", pop_a(), 32'hCAFEF00D);
      chk("b2b word 2", pop_a(), 32'h01234567);

      // Mid-word reset after the 2nd byte_done
      cyc();
      dp = done_pulses_a;
      bytes_a.delete();
      start_a = 1'b1; in_a = 32'hAABBCCDD;
      cyc();
      start_a = 1'b0; in_a = '0;
      nbd = 0; k = 0;
      while (nbd < 2 && k < 200) begin
         cyc();
         if (byte_done_a) nbd++;
         k++;
      end
      chk("midrst byte_done seen", nbd, 32'd2);
      cyc();
      rst = 1'b1;
      cyc();
      chk("midrst busy", {31'd0, busy_a}, 32'd0);
      chk("midrst done", {31'd0, done_a}, 32'd0);
      chk("midrst byte_start", {31'd0, byte_start_a}, 32'd0);
      chk("midrst byte_out", {24'd0, byte_out_a}, 32'd0);
      rst = 1'b0;
      repeat (3) cyc();
      chk("midrst no done", done_pulses_a, dp);
      chk("midrst bytes issued", bytes_a.size(), 32'd2);
      bytes_a.delete();
      start_a = 1'b1; in_a = 32'h11223344;
      cyc();
      start_a = 1'b0; in_a = '0;
      wait_done_a("after rst done", 400);
      chk("after rst word", pop_a(), 32'h11223344);

      // Gapped instance
      bytes_b.delete(); gaps_b.delete();
      start_b = 1'b1; in_b = 32'h80402010;
      cyc();
      start_b = 1'b0; in_b = '0;
      wait_done_b("gap done", 400);
      chk("gap byte count", bytes_b.size(), 32'd4);
      chk("gap word", pop_b(), 32'h80402010);
      chk("gap count", gaps_b.size(), 32'd3);
      for (int i = 0; i < 3; i++) chk("gap done-to-start edges", gaps_b[i], 32'd5);

      // Loopback with random byte latency
      cyc();
      rand_lat = 1;
      bytes_a.delete();
      for (int n = 0; n < 100; n++) begin
         w = $urandom;
         start_a = 1'b1; in_a = w;
         cyc();
         start_a = 1'b0; in_a = '0;
         wait_done_a("loop done", 200);
         chk("loop word", pop_a(), w);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/word_tx.md
Name: word_tx

Overview:
- Serializes one 32-bit word into a sequence of bytes, least-significant byte first, for a downstream byte transmitter (UART TX).
- It is the transmit-side counterpart of the word receiver: four bytes issued in order [7:0], [15:8], [23:16], [31:24] reassemble into the original word at the far end.
- Sits between the core/host-interface logic that produces 32-bit results and the byte-level serial transmitter.

Parameters:
- WORD_BYTES, 4, number of bytes per word; the in width is 8*WORD_BYTES.
- GAP_CYCLES, 0, idle clk cycles inserted between a byte_done and the next byte_start; 0 means no gap.

Ports:
- clk  input  1  system clock; all registers update on the falling edge.
- rst  input  1  synchronous, active-high reset.
- in  input  32  word to send; sampled only when start is accepted.
- start  input  1  request to send in; accepted only in IDLE.
- busy  output  1  high from the edge that accepts start until the edge that returns to IDLE.
- done  output  1  one-cycle pulse; the word's last byte has completed.
- byte_out  output  8  byte presented to the byte transmitter.
- byte_start  output  1  one-cycle pulse requesting transmission of byte_out.
- byte_done  input  1  one-cycle pulse from the byte transmitter; current byte fully sent.

Behaviour:
- Reset (sync, active-high, checked on each falling clk edge):
  - state=IDLE, index=0, shift register=0.
  - busy=0, done=0, byte_start=0, byte_out=8'h00.
  - GAP counter=0.
  - Reset mid-word abandons the word; no done is issued.
- State IDLE:
  - If start=1: shreg<=in, index<=0, busy<=1, go to ISSUE.
  - Otherwise hold.
  - byte_done is ignored in IDLE.
- State ISSUE (one cycle):
  - byte_out<=shreg[7:0], byte_start<=1, go to WAIT.
  - byte_start is high for exactly one cycle; it is cleared on the next edge.
- State WAIT:
  - byte_out is held stable.
  - On byte_done with index==WORD_BYTES-1: done<=1, busy<=0, go to IDLE.
  - On byte_done otherwise: shreg<=shreg>>8, index<=index+1; go to GAP if GAP_CYCLES>0, else go to ISSUE.
- State GAP:
  - Counter counts GAP_CYCLES cycles, then go to ISSUE.
  - byte_done is ignored in GAP.
- done:
  - Registered; high during the first IDLE cycle after completion, cleared on the following edge.
  - A start seen in that same cycle is accepted, so back-to-back words are allowed.
- start while busy=1 is ignored; it is not queued.
- in is don't-care except on the accepting edge.
- byte_done asserted in the same cycle as byte_start (ISSUE) is ignored. The transmitter must complete at least one cycle later.
- Latency:
  - start accepted at edge n; byte_start high between edges n+1 and n+2.
  - With GAP_CYCLES=0, byte k+1's byte_start follows byte k's byte_done by 2 edges (shift, then issue).
- index width is clog2(WORD_BYTES); the last-byte compare uses WORD_BYTES-1, so there is no wrap-around hazard.

Decomposition:
- Shared io package: state enum (IDLE, ISSUE, WAIT, GAP) and BYTE_W=8 constant, reusable by word_rx-side logic.
- No sub-module is needed; the gap counter is inline.
- Loopback pairing with the word receiver is a bench-level construct only.

Test Plan:
- Single word: reset, start with in=32'hDEADBEEF, model byte_done 10 cycles after each byte_start -> byte_out sequence EF, BE, AD, DE; exactly 4 byte_start pulses; one done pulse after the 4th byte_done; busy low afterwards.
- Back-to-back: assert start in the done cycle with in=32'h01234567 after 32'hCAFEF00D -> bytes 0D, F0, FE, CA, then 67, 45, 23, 01; no extra idle cycle.
- Ignored inputs:
  - start pulsed while busy with a different word -> output bytes unchanged; no second word sent.
  - byte_done pulsed in IDLE -> no output activity.
- Mid-word reset: assert rst after the 2nd byte_done of 32'hAABBCCDD -> next edge has all outputs 0, no done; a subsequent start of 32'h11223344 sends 44, 33, 22, 11 from byte 0.
- GAP_CYCLES=3: send 32'h80402010 -> 10, 20, 40, 80; exactly 5 edges from each non-final byte_done to the next byte_start.
- Loopback: byte_out/byte_done fed into the word receiver with randomized 1-20 cycle byte latency, 100 random words -> received word equals sent word every time.
